display_ram_arbiter: RTL
========================

// Module: display_ram_arbiter
// PURPOSE
//  Sole write-port owner of the 64x2 bicolor display RAM (8x8 matrix, addr = {row[2:0],col[2:0]},
//  data = {red,green}) read by the LED scanner. Shares the port between two requesters (0: game
//  logic, 1: cursor/animation) with round-robin arbitration, and runs a built-in clear/fill
//  sequencer that writes one colour to all 64 cells. Sits between game logic and the frame RAM.
// PARAMETERS
//  CELLS        64  number of RAM cells swept by a clear; sweep addresses 0..CELLS-1
//  FAIR_START   0   requester favoured after reset when both request in the same cycle (0 or 1)
// PORTS
//  scan_clk        in   1  clock; all state updates on posedge
//  rst_n           in   1  asynchronous, active-low reset
//  clear_req       in   1  level; start a clear sweep when sampled high in CLR_IDLE
//  clear_color     in   2  {red,green} fill value; latched when clear_req is accepted
//  clear_busy      out  1  high while the sweep is in progress
//  clear_done      out  1  one-cycle pulse after the last cell is written
//  req0/req1       in   1  write request; held, with addr/data stable, until granted
//  addr0/addr1     in   6  target cell
//  data0/data1     in   2  {red,green} value
//  gnt0/gnt1       out  1  one-cycle grant pulse, coincident with that requester's RAM write
//  ram_wr_en       out  1  RAM write strobe
//  ram_wr_addr     out  6  RAM write address
//  ram_wr_data     out  2  RAM write data
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=CLR_IDLE; sweep counter 0; latched colour 00; rr pointer favours FAIR_START.
//  - All outputs registered. A request sampled at edge N produces gnt + ram_wr_* during cycle N+1
//    (1-cycle latency). At most one write per cycle; gnt0 and gnt1 are never high together.
//  - Held-request masking: a requester whose gnt is high in the current cycle is not eligible at
//    the closing edge of that cycle. This gives it one cycle to drop req; one request produces
//    exactly one write.
//  - Round robin: if both requesters are eligible, grant the one not granted most recently and
//    update the pointer. A single eligible requester is granted immediately.
//  - Clear FSM:
//    - CLR_IDLE --clear_req--> CLR_RUN: latch clear_color, counter=0, clear_busy=1.
//    - CLR_RUN: on each edge issue ram_wr_en with addr=counter and data=latched colour, then
//      counter++. Requesters are not granted; they stay pending with req held.
//    - After the write of cell CELLS-1 -> CLR_DONE: clear_busy=0, clear_done=1 for one cycle.
//    - CLR_DONE -> CLR_IDLE unconditionally.
//    - First sweep write: cycle after acceptance. Last write (cell 63): 64 cycles after
//      acceptance. clear_done: 65 cycles after acceptance.
//  - Simultaneous events:
//    - clear_req and reqX sampled at the same edge in CLR_IDLE: the clear wins, reqX waits.
//    - A requester granted in the cycle of clear acceptance completes its write; the sweep starts
//      next cycle and overwrites its cell.
//  - clear_req high in CLR_RUN/CLR_DONE is ignored and not queued. A level still high in CLR_IDLE
//    starts a new sweep; requests are then served only while clear_req is low.
//  - Counter width is clog2(CELLS). No wrap past CELLS-1.
//  - Reset mid-sweep: abort immediately, outputs 0, no clear_done, RAM contents left partial.
// TESTING
//  1 Single write: req0=1, addr0=6'h2A, data0=2'b10 -> next cycle gnt0=1, ram_wr_en=1,
//    addr=2A, data=10; exactly one write even though req0 drops one cycle late.
//  2 Contention: req0 and req1 held continuously after reset (FAIR_START=0) ->
//    grants 0,1,0,1 every cycle; never both high.
//  3 Clear: clear_req pulse with clear_color=2'b01 -> 64 consecutive writes, addr 0..63,
//    data 01; clear_busy high exactly those 64 cycles; clear_done pulse at cycle 65.
//  4 Clear vs request: req1 asserted at sweep cell 10 -> no gnt1 during sweep; gnt1 in the
//    cycle after clear_done; its write lands after cell 63.
//  5 Ignored re-trigger: clear_req pulsed again at cell 30 -> still one sweep, one clear_done.
//  6 Reset at cell 20: rst_n low 1 cycle -> all outputs 0, no clear_done; a new clear_req
//    restarts the sweep at addr 0.

Source files
------------

// File: rtl/display_ram_arbiter.sv
// display_ram_arbiter: sole write-port owner of the 64x2 bicolor frame RAM.
// Round-robin between two requesters, plus a clear/fill sweeper.
//
// Ports:
//   scan_clk, rst_n          clock, async active-low reset
//   clear_req, clear_color   start a fill sweep with {red,green}
//   clear_busy, clear_done   sweep in progress / one-cycle end pulse
//   reqN, addrN, dataN       held write request (N = 0 game, 1 cursor)
//   gntN                     one-cycle grant, same cycle as the write
//   ram_wr_en/addr/data      registered RAM write port
module display_ram_arbiter #(
    parameter int CELLS      = 64,
    parameter bit FAIR_START = 1'b0
) (
    input  logic       scan_clk,
    input  logic       rst_n,
    input  logic       clear_req,
    input  logic [1:0] clear_color,
    output logic       clear_busy,
    output logic       clear_done,
    input  logic       req0,
    input  logic [5:0] addr0,
    input  logic [1:0] data0,
    input  logic       req1,
    input  logic [5:0] addr1,
    input  logic [1:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       ram_wr_en,
    output logic [5:0] ram_wr_addr,
    output logic [1:0] ram_wr_data
);

    localparam int CW = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CELLS - 1);

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_RUN,
        CLR_DONE
    } clr_state_e;

    clr_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    col_q, col_d;
    // ptr_q names the requester that wins a tie
    logic          ptr_q, ptr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          wr_en_q, wr_en_d;
    logic [5:0]    wr_addr_q, wr_addr_d;
    logic [1:0]    wr_data_q, wr_data_d;

    logic elig0, elig1;
    logic go_clr, go0, go1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        ptr_d     = ptr_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;

        // A requester granted this cycle sits out the closing edge,
        // giving it a cycle to drop req without a second write.
        elig0  = req0 & ~gnt0_q;
        elig1  = req1 & ~gnt1_q;
        go_clr = clear_req;
        go1    = ~clear_req & elig1 & (~elig0 | ptr_q);
        go0    = ~clear_req & elig0 & ~go1;

        unique case (state_q)
            CLR_IDLE: begin
                unique case (1'b1)
                    go_clr: begin
                        state_d = CLR_RUN;
                        cnt_d   = '0;
                        col_d   = clear_color;
                    end
                    go1: begin
                        gnt1_d    = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr1;
                        wr_data_d = data1;
                        ptr_d     = 1'b0;
                    end
                    go0: begin
                        gnt0_d    = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr0;
                        wr_data_d = data0;
                        ptr_d     = 1'b1;
                    end
                    default: ;
                endcase
            end
            CLR_RUN: begin
                busy_d    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = 6'(cnt_q);
                wr_data_d = col_q;
                if (cnt_q == LAST) begin
                    state_d = CLR_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CLR_DONE: begin
                done_d  = 1'b1;
                state_d = CLR_IDLE;
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLR_IDLE;
            cnt_q     <= '0;
            col_q     <= '0;
            ptr_q     <= FAIR_START;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign clear_busy  = busy_q;
    assign clear_done  = done_q;
    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign ram_wr_en   = wr_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;

endmodule
